// File: rtl/inert_spi_serf_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : inert_serf_pkg
// Brief  : Register map, field indices and FSM state type for inert_spi_serf.
// Rev    : 1.0  initial release
// ============================================================================
package inert_serf_pkg;

  localparam logic [6:0] ADDR_INT_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHO_AM_I = 7'h0F;
  localparam logic [6:0] ADDR_CTRL2_G  = 7'h11;
  localparam logic [6:0] ADDR_CTRL7_G  = 7'h14;
  localparam logic [6:0] ADDR_STATUS   = 7'h1E;
  localparam logic [6:0] ADDR_YAWL     = 7'h26;
  localparam logic [6:0] ADDR_YAWH     = 7'h27;

  localparam int INT_EN_BIT = 1;
  localparam int GDA_BIT    = 1;
  localparam int OVR_BIT    = 7;

  localparam logic [4:0] CMD_BITS   = 5'd8;
  localparam logic [4:0] FRAME_BITS = 5'd16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    DATA   = 2'd2,
    COMMIT = 2'd3
  } serf_state_t;

endpackage
`default_nettype wire

// File: rtl/inert_spi_serf_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : inert_spi_serf_if
// Brief  : SPI link plus yaw-sample feed between initiator/sensor model and serf.
// Rev    : 1.0  initial release
// ============================================================================
interface inert_spi_serf_if;

  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [15:0] yaw_in;
  logic        yaw_vld;
  logic        INT;

  modport master (
    output SS_n, SCLK, MOSI, yaw_in, yaw_vld,
    input  MISO, INT
  );

  modport slave (
    input  SS_n, SCLK, MOSI, yaw_in, yaw_vld,
    output MISO, INT
  );

endinterface
`default_nettype wire

// File: rtl/inert_spi_serf_shift.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : spi_serf_shift
// Brief  : SPI pin synchronisers, edge detect, rx/tx shift registers, bit count.
// Rev    : 1.0  initial release
// ============================================================================
module spi_serf_shift
  import inert_serf_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_ss_n,
  input  wire logic        i_sclk,
  input  wire logic        i_mosi,
  input  wire logic        i_shift_en,
  input  wire logic        i_start,
  input  wire logic        i_tx_load,
  input  wire logic [15:0] i_tx_data,
  output logic             o_ss_fall,
  output logic             o_ss_rise,
  output logic             o_cmd_vld,
  output logic             o_frame_done,
  output logic             o_abort,
  output logic [7:0]       o_rx_byte,
  output logic             o_miso
);

  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_ss_prev;
  logic                   r_sclk_prev;
  logic [7:0]             r_rx_shreg;
  logic [15:0]            r_tx_shreg;
  logic [4:0]             r_bit_cnt;
  logic                   r_miso;

  logic w_ss;
  logic w_sclk;
  logic w_mosi;
  logic w_sclk_rise;
  logic w_shift;

  // Sync flops reset to the idle bus levels so reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ss_sync   <= '1;
      r_sclk_sync <= '1;
      r_mosi_sync <= '0;
      r_ss_prev   <= 1'b1;
      r_sclk_prev <= 1'b1;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_ss_prev   <= r_ss_sync[SYNC_STAGES-1];
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_shift     = w_sclk_rise & ~w_ss & i_shift_en;

  // Only the low byte of the receive path is ever consumed: it holds the
  // command after rise 8 and the write data after rise 16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_shreg <= 8'h00;
      r_tx_shreg <= 16'h0000;
      r_bit_cnt  <= 5'd0;
      r_miso     <= 1'b1;
    end else begin
      if (i_start) begin
        r_bit_cnt  <= 5'd0;
        r_tx_shreg <= 16'h0000;
      end else begin
        if (w_shift) begin
          r_rx_shreg <= {r_rx_shreg[6:0], w_mosi};
          r_bit_cnt  <= r_bit_cnt + 5'd1;
        end
        if (i_tx_load) begin
          r_tx_shreg <= i_tx_data;
        end else if (w_shift) begin
          r_tx_shreg <= {r_tx_shreg[14:0], 1'b0};
        end
      end
      r_miso <= w_ss ? 1'b1 : r_tx_shreg[15];
    end
  end

  assign o_ss_fall    = r_ss_prev & ~w_ss;
  assign o_ss_rise    = ~r_ss_prev & w_ss;
  assign o_cmd_vld    = (r_bit_cnt == CMD_BITS);
  assign o_frame_done = o_ss_rise & (r_bit_cnt == FRAME_BITS);
  assign o_abort      = o_ss_rise & (r_bit_cnt != FRAME_BITS);
  assign o_rx_byte    = r_rx_shreg;
  assign o_miso       = r_miso;

endmodule
`default_nettype wire

// File: rtl/inert_spi_serf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : inert_spi_serf
// Brief  : SPI serf modelling the inertial sensor: frame FSM, registers, INT.
//          Optional STATUS register at 0x1E under `INERT_SERF_STATUS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module inert_spi_serf
  import inert_serf_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h6A,
  parameter int         SYNC_STAGES  = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  inert_spi_serf_if.slave  bus
);

  serf_state_t r_state;
  serf_state_t w_next;

  logic [7:0]  r_cmd;
  logic [7:0]  r_int_ctrl;
  logic [7:0]  r_ctrl2_g;
  logic [7:0]  r_ctrl7_g;
  logic [15:0] r_yaw;
  logic [7:0]  r_yawh_shadow;
  logic        r_int;

  logic        w_start;
  logic        w_tx_load;
  logic        w_cmd_latch;
  logic        w_shift_en;
  logic        w_ss_fall;
  logic        w_ss_rise;
  logic        w_cmd_vld;
  logic        w_frame_done;
  logic        w_abort;
  logic [7:0]  w_rx_byte;
  logic        w_miso;
  logic [7:0]  w_rd_byte;
  logic        w_commit;
  logic        w_rw;
  logic [6:0]  w_addr;
  logic        w_yawh_rd_done;
  logic [7:0]  w_status;

  spi_serf_shift #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_shift (
    .clk          (clk),
    .rst          (rst),
    .i_ss_n       (bus.SS_n),
    .i_sclk       (bus.SCLK),
    .i_mosi       (bus.MOSI),
    .i_shift_en   (w_shift_en),
    .i_start      (w_start),
    .i_tx_load    (w_tx_load),
    .i_tx_data    ({w_rd_byte, 8'h00}),
    .o_ss_fall    (w_ss_fall),
    .o_ss_rise    (w_ss_rise),
    .o_cmd_vld    (w_cmd_vld),
    .o_frame_done (w_frame_done),
    .o_abort      (w_abort),
    .o_rx_byte    (w_rx_byte),
    .o_miso       (w_miso)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_tx_load   = 1'b0;
    w_cmd_latch = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_start = 1'b1;
          w_next  = CMD;
        end
      end
      CMD: begin
        if (w_ss_fall) begin
          w_start = 1'b1;
          w_next  = CMD;
        end else if (w_ss_rise) begin
          w_next = IDLE;
        end else if (w_cmd_vld) begin
          w_cmd_latch = 1'b1;
          w_tx_load   = w_rx_byte[7];
          w_next      = DATA;
        end
      end
      DATA: begin
        if (w_ss_fall) begin
          w_start = 1'b1;
          w_next  = CMD;
        end else if (w_frame_done) begin
          w_next = COMMIT;
        end else if (w_abort) begin
          w_next = IDLE;
        end
      end
      COMMIT: begin
        if (w_ss_fall) begin
          w_start = 1'b1;
          w_next  = CMD;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_shift_en     = (r_state == CMD) || (r_state == DATA);
  assign w_commit       = (r_state == COMMIT);
  assign w_rw           = r_cmd[7];
  assign w_addr         = r_cmd[6:0];
  assign w_yawh_rd_done = w_commit & w_rw & (w_addr == ADDR_YAWH);

`ifdef INERT_SERF_STATUS_EN
  logic r_gda;
  logic r_ovr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gda <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (bus.yaw_vld)         r_gda <= 1'b1;
      else if (w_yawh_rd_done) r_gda <= 1'b0;
      if (bus.yaw_vld && r_gda)                              r_ovr <= 1'b1;
      else if (w_commit && w_rw && (w_addr == ADDR_STATUS)) r_ovr <= 1'b0;
    end
  end

  always_comb begin
    w_status          = 8'h00;
    w_status[GDA_BIT] = r_gda;
    w_status[OVR_BIT] = r_ovr;
  end
`else
  assign w_status = 8'h00;
`endif

  // Decoded from the live rx byte: used only in the cycle the command latches.
  always_comb begin
    w_rd_byte = 8'h00;
    case (w_rx_byte[6:0])
      ADDR_INT_CTRL: w_rd_byte = r_int_ctrl;
      ADDR_WHO_AM_I: w_rd_byte = WHO_AM_I_VAL;
      ADDR_CTRL2_G:  w_rd_byte = r_ctrl2_g;
      ADDR_CTRL7_G:  w_rd_byte = r_ctrl7_g;
      ADDR_STATUS:   w_rd_byte = w_status;
      ADDR_YAWL:     w_rd_byte = r_yaw[7:0];
      ADDR_YAWH:     w_rd_byte = r_yawh_shadow;
      default:       w_rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd         <= 8'h00;
      r_int_ctrl    <= 8'h00;
      r_ctrl2_g     <= 8'h00;
      r_ctrl7_g     <= 8'h00;
      r_yaw         <= 16'h0000;
      r_yawh_shadow <= 8'h00;
    end else begin
      if (w_cmd_latch) begin
        r_cmd <= w_rx_byte;
        // Freeze the high byte alongside the low-byte read for a coherent pair.
        if (w_rx_byte[7] && (w_rx_byte[6:0] == ADDR_YAWL)) begin
          r_yawh_shadow <= r_yaw[15:8];
        end
      end
      if (bus.yaw_vld) begin
        r_yaw <= bus.yaw_in;
      end
      if (w_commit && !w_rw) begin
        case (w_addr)
          ADDR_INT_CTRL: r_int_ctrl <= w_rx_byte;
          ADDR_CTRL2_G:  r_ctrl2_g  <= w_rx_byte;
          ADDR_CTRL7_G:  r_ctrl7_g  <= w_rx_byte;
          default: ;
        endcase
      end
    end
  end

  // Set has priority over the read-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int <= 1'b0;
    end else if (bus.yaw_vld && r_int_ctrl[INT_EN_BIT]) begin
      r_int <= 1'b1;
    end else if (w_yawh_rd_done) begin
      r_int <= 1'b0;
    end
  end

  assign bus.MISO = w_miso;
  assign bus.INT  = r_int;

endmodule
`default_nettype wire

// File: tb/tb_inert_spi_serf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_inert_spi_serf
// Brief  : Scoreboarded bench: SPI initiator + sensor feed vs. a register-map model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_inert_spi_serf;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inert_spi_serf_if bus();

  inert_spi_serf #(
    .WHO_AM_I_VAL (8'h6A),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic        mon_vld  = 1'b0;
  logic [15:0] mon_data = 16'h0000;

  logic [7:0]  m_reg [0:127];
  logic [15:0] m_yaw;
  logic [7:0]  m_shadow;
  logic        m_int;
  logic        m_gda;
  logic        m_ovr;

  function automatic void model_reset();
    for (int i = 0; i < 128; i++) m_reg[i] = 8'h00;
    m_yaw    = 16'h0000;
    m_shadow = 8'h00;
    m_int    = 1'b0;
    m_gda    = 1'b0;
    m_ovr    = 1'b0;
  endfunction

  function automatic logic [7:0] model_read(input logic [6:0] a);
    case (a)
      7'h0F: return 8'h6A;
      7'h26: return m_yaw[7:0];
      7'h27: return m_shadow;
`ifdef INERT_SERF_STATUS_EN
      7'h1E: return {m_ovr, 5'b00000, m_gda, 1'b0};
`endif
      default: return m_reg[a];
    endcase
  endfunction

  function automatic logic [15:0] model_frame(input logic [15:0] w, input int rises);
    logic       rw;
    logic [6:0] a;
    logic [7:0] rd;
    rw = w[15];
    a  = w[14:8];
    rd = 8'h00;
    if (rises >= 8 && rw) begin
      rd = model_read(a);
      if (a == 7'h26) m_shadow = m_yaw[15:8];
    end
    if (rises == 16) begin
      if (!rw && (a == 7'h0D || a == 7'h11 || a == 7'h14)) m_reg[a] = w[7:0];
      if (rw && a == 7'h27) begin
        m_int = 1'b0;
        m_gda = 1'b0;
      end
      if (rw && a == 7'h1E) m_ovr = 1'b0;
    end
    return {8'h00, rd};
  endfunction

  function automatic void model_yaw(input logic [15:0] v, input logic gda_seen);
    if (gda_seen) m_ovr = 1'b1;
    m_gda = 1'b1;
    m_yaw = v;
    if (m_reg[7'h0D][1]) m_int = 1'b1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // yaw_at > 0 strobes yaw_vld that many clocks after SS_n rises.
  task automatic spi_frame(input logic [15:0] w, input int rises,
                           input int yaw_at, input logic [15:0] yaw_v);
    logic [15:0] got;
    logic [15:0] e;
    logic        g;
    got = 16'h0000;
    g   = m_gda;
    e   = model_frame(w, rises);
    if (yaw_at > 0) model_yaw(yaw_v, g);
    if (rises == 16) exp_q.push_back(e);
    bus.SS_n = 1'b0;
    tick(HALF);
    for (int i = 0; i < rises; i++) begin
      bus.SCLK = 1'b0;
      bus.MOSI = w[15-i];
      tick(HALF);
      got = {got[14:0], bus.MISO};
      bus.SCLK = 1'b1;
      tick(HALF);
    end
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    for (int c = 1; c <= HALF; c++) begin
      tick(1);
      if (c == yaw_at) begin
        bus.yaw_in  = yaw_v;
        bus.yaw_vld = 1'b1;
      end else begin
        bus.yaw_vld = 1'b0;
      end
    end
    if (rises == 16) begin
      mon_data = got;
      mon_vld  = 1'b1;
      tick(1);
      mon_vld  = 1'b0;
    end
  endtask

  task automatic rd(input logic [6:0] a);
    spi_frame({1'b1, a, 8'h00}, 16, 0, 16'h0000);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    spi_frame({1'b0, a, d}, 16, 0, 16'h0000);
  endtask

  task automatic pulse_yaw(input logic [15:0] v);
    bus.yaw_in  = v;
    bus.yaw_vld = 1'b1;
    model_yaw(v, m_gda);
    tick(1);
    bus.yaw_vld = 1'b0;
    chk("int_after_vld", {15'd0, bus.INT}, {15'd0, m_int});
  endtask

  always @(posedge clk) begin
    if (mon_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_frame: got 0x%04h with no expected entry", mon_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (mon_data !== e) begin
          failures++;
          $display("FAIL sb_frame: got 0x%04h expected 0x%04h", mon_data, e);
        end
      end
    end
  end

  logic [6:0] addr_tbl [0:7];

  initial begin
    addr_tbl[0] = 7'h0D; addr_tbl[1] = 7'h0F; addr_tbl[2] = 7'h11; addr_tbl[3] = 7'h14;
    addr_tbl[4] = 7'h1E; addr_tbl[5] = 7'h26; addr_tbl[6] = 7'h27; addr_tbl[7] = 7'h05;
    bus.SS_n    = 1'b1;
    bus.SCLK    = 1'b1;
    bus.MOSI    = 1'b0;
    bus.yaw_in  = 16'h0000;
    bus.yaw_vld = 1'b0;
    model_reset();
    tick(3);
    chk("reset_miso", {15'd0, bus.MISO}, 16'h0001);
    chk("reset_int",  {15'd0, bus.INT},  16'h0000);
    rst = 1'b0;
    tick(3);

    rd(7'h0F);
    chk("int_idle", {15'd0, bus.INT}, 16'h0000);

    wr(7'h0D, 8'h02);
    pulse_yaw(16'hFE35);
    rd(7'h26);
    chk("int_held", {15'd0, bus.INT}, 16'h0001);
    rd(7'h27);
    chk("int_cleared", {15'd0, bus.INT}, {15'd0, m_int});

    pulse_yaw(16'h1234);
    rd(7'h26);
    pulse_yaw(16'h5678);
    rd(7'h27);
    rd(7'h26);
    rd(7'h27);

    spi_frame(16'h1160, 11, 0, 16'h0000);
    rd(7'h11);
    wr(7'h11, 8'h60);
    rd(7'h11);
    chk("miso_idle", {15'd0, bus.MISO}, 16'h0001);

    pulse_yaw(16'h0BAD);
    spi_frame(16'hA700, 16, SYNC + 1, 16'hC0DE);
    chk("int_set_wins", {15'd0, bus.INT}, 16'h0001);

    bus.SS_n = 1'b0;
    tick(HALF);
    for (int i = 0; i < 5; i++) begin
      bus.SCLK = 1'b0; tick(HALF);
      bus.SCLK = 1'b1; tick(HALF);
    end
    rst = 1'b1;
    tick(2);
    chk("midframe_rst_miso", {15'd0, bus.MISO}, 16'h0001);
    chk("midframe_rst_int",  {15'd0, bus.INT},  16'h0000);
    bus.SS_n = 1'b1;
    model_reset();
    tick(3);
    rst = 1'b0;
    tick(3);
    rd(7'h0F);
    rd(7'h0D);

`ifdef INERT_SERF_STATUS_EN
    pulse_yaw(16'h1111);
    pulse_yaw(16'h2222);
    rd(7'h1E);
    rd(7'h1E);
    rd(7'h27);
    rd(7'h1E);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [6:0] a;
      a = addr_tbl[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0: wr(a, 8'($urandom));
        1: rd(a);
        2: pulse_yaw(16'($urandom));
        default: spi_frame({1'($urandom), a, 8'($urandom)}, $urandom_range(0, 15), 0, 16'h0000);
      endcase
      chk("rand_int", {15'd0, bus.INT}, {15'd0, m_int});
    end

    for (int t = 0; t < 100 && exp_q.size() != 0; t++) tick(1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d frames outstanding, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
